// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding
// and the fixed instruction/address constants used by the fetch logic.
package if_pkg;

  // Fetch FSM states.
  //   SKIP : one post-reset cycle that bumps the PC off its reset sentinel
  //   REQ  : request outstanding to instruction memory, waiting for grant
  //   WAIT : granted, waiting for the single response
  //   HOLD : instruction word held for decode
  //   DROP : a redirect orphaned the in-flight fetch; swallow its response
  typedef enum logic [2:0] {
    ST_SKIP = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0 -- substituted for a fetch that must not reach memory.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Value the PC register holds out of reset; one pc+4 step lands on 0.
  localparam logic [31:0] PC_RESET_SENTINEL = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage sitting directly after the PC register.
// Issues one request per PC over a grant/response handshake, holds the
// returned word for decode and drives the PC register's load enable so the
// PC only advances on hand-off or redirect.
// Optional build macro: IF_FETCH_ALIGN_CHK_EN -- misaligned PCs are not
// sent to memory; a NOP is presented instead with fetch_misalign raised.
module if_fetch
  import if_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit RESET_SKIP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_write,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
`ifdef IF_FETCH_ALIGN_CHK_EN
  output logic            fetch_misalign,
`endif
  input  logic            inst_ready
);

  localparam fetch_state_e RESET_STATE = RESET_SKIP ? ST_SKIP : ST_REQ;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
`ifdef IF_FETCH_ALIGN_CHK_EN
  logic            misalign_q, misalign_d;
`endif

  logic            req_raw;
  logic            pc_write_raw;

  // Next-state, capture and handshake decode for the fetch FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
`ifdef IF_FETCH_ALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif
    req_raw      = 1'b0;
    pc_write_raw = 1'b0;

    unique case (state_q)
      ST_SKIP: begin
        pc_write_raw = 1'b1;
        state_d      = ST_REQ;
      end

      ST_REQ: begin
`ifdef IF_FETCH_ALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
          // Never hand a misaligned address to memory; fake a NOP instead.
          if (redirect) begin
            pc_write_raw = 1'b1;
          end else begin
            inst_d       = XLEN'(NOP_INST);
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            misalign_d   = 1'b1;
            state_d      = ST_HOLD;
          end
        end else begin
`endif
          req_raw = 1'b1;
          if (redirect) begin
            // A grant in the same cycle is already committed at memory,
            // so its response must be swallowed in DROP.
            pc_write_raw = 1'b1;
            if (imem_gnt) state_d = ST_DROP;
          end else if (imem_gnt) begin
            inst_pc_d = pc;
            state_d   = ST_WAIT;
          end
`ifdef IF_FETCH_ALIGN_CHK_EN
        end
`endif
      end

      ST_WAIT: begin
        if (imem_rvalid && !redirect) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
`ifdef IF_FETCH_ALIGN_CHK_EN
          misalign_d   = 1'b0;
`endif
          state_d      = ST_HOLD;
        end else if (imem_rvalid && redirect) begin
          // Response arrives with the redirect: nothing left in flight.
          pc_write_raw = 1'b1;
          state_d      = ST_REQ;
        end else if (redirect) begin
          pc_write_raw = 1'b1;
          state_d      = ST_DROP;
        end
      end

      ST_HOLD: begin
        // Redirect wins over a decode accept; either way the PC moves on.
        if (redirect || inst_ready) begin
          pc_write_raw = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end

      ST_DROP: begin
        if (redirect)    pc_write_raw = 1'b1;
        if (imem_rvalid) state_d      = ST_REQ;
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State and capture registers; reset returns to the post-reset state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= RESET_STATE;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
`ifdef IF_FETCH_ALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef IF_FETCH_ALIGN_CHK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // The reset state may itself decode to a request or PC load, so both
  // strobes are masked while rst is held.
  assign imem_req   = req_raw & ~rst;
  assign pc_write   = pc_write_raw & ~rst;
  assign imem_addr  = pc;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
`ifdef IF_FETCH_ALIGN_CHK_EN
  assign fetch_misalign = misalign_q & inst_valid_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. Models the upstream PC register and
// drives the memory handshake directly; instructions expected at decode
// are queued when their response is driven and popped at hand-off.
module tb_if_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_write;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IF_FETCH_ALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int total = 0;
  int bad   = 0;
  int gnt_cnt = 0;
  logic [63:0] sb_q[$];

  if_fetch #(.XLEN(32), .RESET_SKIP(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
`ifdef IF_FETCH_ALIGN_CHK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  // Upstream PC register: loads redirect target or pc+4 on pc_write.
  always @(posedge clk or posedge rst) begin
    if (rst)           pc <= PC_RESET_SENTINEL;
    else if (pc_write) pc <= redirect ? target : pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] epc, input logic [31:0] einst);
    sb_q.push_back({epc, einst});
  endtask

  // Hand-off monitor: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("handoff_inst", inst, e[31:0]);
        check("handoff_pc", inst_pc, e[63:32]);
        check("handoff_pc_write", {31'd0, pc_write}, 32'd1);
      end
    end
    if (!rst && inst_valid && inst == 32'hDEAD_BEEF)
      check("dropped_word_leak", inst, 32'h0);
    if (!rst && imem_req && imem_gnt) gnt_cnt++;
  end

  // One clean fetch from REQ with decode ready; ends at the next REQ cycle.
  task automatic fetch_one(input logic [31:0] epc, input logic [31:0] data);
    imem_gnt = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("f1_req", {31'd0, imem_req}, 32'd1);
    check("f1_addr", imem_addr, epc);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    sb_push(epc, data);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("f1_valid", {31'd0, inst_valid}, 32'd1);
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    int g0;
    rst = 1'b1; redirect = 1'b0; target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values
    @(negedge clk);
    check("rst_pc_write", {31'd0, pc_write}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    step();
    rst = 1'b0;

    // SKIP cycle: PC load without a request
    @(negedge clk);
    check("skip_pc_write", {31'd0, pc_write}, 32'd1);
    check("skip_imem_req", {31'd0, imem_req}, 32'd0);
    step();

    // Best-case fetch at 0x0 with decode ready
    imem_gnt = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("t2_req", {31'd0, imem_req}, 32'd1);
    check("t2_addr", imem_addr, 32'h0);
    check("t2_pcw_req", {31'd0, pc_write}, 32'd0);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    sb_push(32'h0, 32'h0050_0093);
    @(negedge clk);
    check("t2_wait_req", {31'd0, imem_req}, 32'd0);
    check("t2_wait_pcw", {31'd0, pc_write}, 32'd0);
    check("t2_wait_valid", {31'd0, inst_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("t2_valid", {31'd0, inst_valid}, 32'd1);
    step();
    @(negedge clk);
    check("t2_next_req", {31'd0, imem_req}, 32'd1);
    check("t2_next_addr", imem_addr, 32'h4);
    step();

    // Decode back-pressure for 5 cycles in HOLD
    imem_gnt = 1'b1; inst_ready = 1'b0;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    sb_push(32'h4, 32'h00A0_0113);
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, inst_valid}, 32'd1);
      check("t3_hold_inst", inst, 32'h00A0_0113);
      check("t3_hold_pc", inst_pc, 32'h4);
      check("t3_hold_pcw", {31'd0, pc_write}, 32'd0);
      step();
    end
    inst_ready = 1'b1;
    @(negedge clk);
    check("t3_release_pcw", {31'd0, pc_write}, 32'd1);
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    check("t3_release_once", {31'd0, pc_write}, 32'd0);
    check("t3_next_addr", imem_addr, 32'h8);

    // Redirect in WAIT; orphan response 3 cycles later
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect = 1'b1; target = 32'h100;
    @(negedge clk);
    check("t4_redir_pcw", {31'd0, pc_write}, 32'd1);
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_drop_pcw", {31'd0, pc_write}, 32'd0);
      check("t4_drop_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_orphan_pcw", {31'd0, pc_write}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("t4_target_req", {31'd0, imem_req}, 32'd1);
    check("t4_target_addr", imem_addr, 32'h100);
    check("t4_no_valid", {31'd0, inst_valid}, 32'd0);
    step();
    fetch_one(32'h100, 32'h0000_0517);

    // Redirect coincident with grant
    g0 = gnt_cnt;
    imem_gnt = 1'b1; redirect = 1'b1; target = 32'h200;
    @(negedge clk);
    check("t5_pcw", {31'd0, pc_write}, 32'd1);
    step();
    imem_gnt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_drop_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    @(negedge clk);
    check("t5_orphan_pcw", {31'd0, pc_write}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    fetch_one(32'h200, 32'h0010_8093);
    check("t5_grants", gnt_cnt - g0, 32'd2);

    // Response and redirect in the same WAIT cycle
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_1111;
    redirect = 1'b1; target = 32'h300;
    @(negedge clk);
    check("t6_pcw", {31'd0, pc_write}, 32'd1);
    step();
    imem_rvalid = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("t6_req", {31'd0, imem_req}, 32'd1);
    check("t6_addr", imem_addr, 32'h300);
    check("t6_no_valid", {31'd0, inst_valid}, 32'd0);
    step();

    // Redirect while holding with decode stalled
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297;
    step();
    imem_rvalid = 1'b0; redirect = 1'b1; target = 32'h400;
    @(negedge clk);
    check("t7_hold_valid", {31'd0, inst_valid}, 32'd1);
    check("t7_pcw", {31'd0, pc_write}, 32'd1);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("t7_cleared", {31'd0, inst_valid}, 32'd0);
    check("t7_addr", imem_addr, 32'h400);
    step();

`ifdef IF_FETCH_ALIGN_CHK_EN
    // Misaligned PC produces a NOP without touching memory
    redirect = 1'b1; target = 32'h6;
    @(negedge clk);
    check("al_pcw", {31'd0, pc_write}, 32'd1);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("al_no_req", {31'd0, imem_req}, 32'd0);
    step();
    inst_ready = 1'b1;
    sb_push(32'h6, NOP_INST);
    @(negedge clk);
    check("al_valid", {31'd0, inst_valid}, 32'd1);
    check("al_inst", inst, NOP_INST);
    check("al_misalign", {31'd0, fetch_misalign}, 32'd1);
    check("al_inst_pc", inst_pc, 32'h6);
    step();
    inst_ready = 1'b0;
`endif

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
